// File: rtl/vp_stream_core.sv
// vp_stream_core: RGB point-operation stage (pass/gray/invert-gray/threshold) with SOF/EOL tags and credit-guarded output FIFO
//   i_clk, i_rstn                 clock, synchronous active-low reset
//   i_mode, i_thresh              point operation (latched at SOF) and per-pixel threshold
//   i_data_valid, i_data          input pixel stream {R,G,B}; o_data_ready is registered
//   o_data_valid, o_data          FIFO head (show-ahead), popped by i_data_ready
//   o_sof, o_eol                  head pixel is line 0 col 0 / col RL-1
//   o_fill                        FIFO occupancy 0..DEPTH
//   o_frame_done                  pulse the cycle after the last pixel of a frame is accepted
module vp_stream_core #(
   parameter int DW      = 12,
   parameter int RL      = 640,
   parameter int NROWS   = 480,
   parameter int FIFO_AW = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rstn,
   input  logic [1:0]           i_mode,
   input  logic [DW/3-1:0]      i_thresh,
   input  logic                 i_data_valid,
   output logic                 o_data_ready,
   input  logic [DW-1:0]        i_data,
   input  logic                 i_data_ready,
   output logic                 o_data_valid,
   output logic [DW-1:0]        o_data,
   output logic                 o_sof,
   output logic                 o_eol,
   output logic [FIFO_AW:0]     o_fill,
   output logic                 o_frame_done
);
   localparam int CW    = DW / 3;
   localparam int PW    = CW + 8;
   localparam int SW    = CW + 10;
   localparam int FW    = DW + 2;
   localparam int DEPTH = 2 ** FIFO_AW;
   localparam int XW    = RL > 1 ? $clog2(RL) : 1;
   localparam int YW    = NROWS > 1 ? $clog2(NROWS) : 1;
   localparam int KW    = FIFO_AW + 2;
   localparam logic [XW-1:0]      COL_LAST = XW'(RL - 1);
   localparam logic [YW-1:0]      ROW_LAST = YW'(NROWS - 1);
   localparam logic [FIFO_AW:0]   FULL     = (FIFO_AW + 1)'(DEPTH);

   logic [XW-1:0]      col_q, col_d;
   logic [YW-1:0]      row_q, row_d;
   logic [1:0]         mode_q, mode_d;
   logic               rdy_q, rdy_d, fd_q, fd_d;
   logic               v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
   logic [DW-1:0]      p1_q, p1_d, p2_q, p2_d, out3_q, out3_d;
   logic [PW-1:0]      r1_q, r1_d, g1_q, g1_d, b1_q, b1_d;
   logic [1:0]         m1_q, m1_d, m2_q, m2_d;
   logic [CW-1:0]      t1_q, t1_d, t2_q, t2_d, gray2_q, gray2_d;
   logic [1:0]         tag1_q, tag1_d, tag2_q, tag2_d, tag3_q, tag3_d;
   logic [FIFO_AW-1:0] wp_q, wp_d, rp_q, rp_d;
   logic [FIFO_AW:0]   fill_q, fill_d;
   logic [FW-1:0]      mem_q [DEPTH];
   logic               accept, sof_in, eol_in, last_row, push, pop;
   logic [SW-1:0]      sum;
   logic [KW-1:0]      credit;
   logic [FW-1:0]      head;

   always_comb begin
      accept   = i_data_valid && rdy_q;
      sof_in   = col_q == '0 && row_q == '0;
      eol_in   = col_q == COL_LAST;
      last_row = row_q == ROW_LAST;
      // push on full cannot happen while credits hold; the guard keeps the FIFO safe regardless
      push     = v3_q && fill_q != FULL;
      pop      = fill_q != '0 && i_data_ready;
      col_d    = accept ? (eol_in ? '0 : col_q + XW'(1)) : col_q;
      row_d    = (accept && eol_in) ? (last_row ? '0 : row_q + YW'(1)) : row_q;
      mode_d   = (accept && sof_in) ? i_mode : mode_q;
      fd_d     = accept && eol_in && last_row;
      // the SOF pixel itself already uses the newly sampled mode
      v1_d     = accept;
      p1_d     = i_data;
      r1_d     = PW'(i_data[DW-1 -: CW]) * PW'(77);
      g1_d     = PW'(i_data[2*CW-1 -: CW]) * PW'(150);
      b1_d     = PW'(i_data[CW-1:0]) * PW'(29);
      m1_d     = sof_in ? i_mode : mode_q;
      t1_d     = i_thresh;
      tag1_d   = {sof_in, eol_in};
      // coefficients sum to 256, so the shifted sum always fits in CW bits
      sum      = SW'(r1_q) + SW'(g1_q) + SW'(b1_q);
      v2_d     = v1_q;
      p2_d     = p1_q;
      gray2_d  = sum[CW+7:8];
      m2_d     = m1_q;
      t2_d     = t1_q;
      tag2_d   = tag1_q;
      v3_d     = v2_q;
      out3_d   = m2_q == 2'd0 ? p2_q :
                 m2_q == 2'd1 ? {3{gray2_q}} :
                 m2_q == 2'd2 ? ~{3{gray2_q}} :
                 {DW{gray2_q >= t2_q}};
      tag3_d   = tag2_q;
      wp_d     = push ? wp_q + FIFO_AW'(1) : wp_q;
      rp_d     = pop ? rp_q + FIFO_AW'(1) : rp_q;
      fill_d   = (push && !pop) ? fill_q + 1'b1 : (pop && !push) ? fill_q - 1'b1 : fill_q;
      // every pixel in the pipe already owns a FIFO slot
      credit   = KW'(fill_d) + KW'(v1_d) + KW'(v2_d) + KW'(v3_d);
      rdy_d    = credit < KW'(DEPTH);
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         col_q   <= '0;
         row_q   <= '0;
         mode_q  <= '0;
         rdy_q   <= 1'b0;
         fd_q    <= 1'b0;
         v1_q    <= 1'b0;
         v2_q    <= 1'b0;
         v3_q    <= 1'b0;
         p1_q    <= '0;
         p2_q    <= '0;
         out3_q  <= '0;
         r1_q    <= '0;
         g1_q    <= '0;
         b1_q    <= '0;
         m1_q    <= '0;
         m2_q    <= '0;
         t1_q    <= '0;
         t2_q    <= '0;
         gray2_q <= '0;
         tag1_q  <= '0;
         tag2_q  <= '0;
         tag3_q  <= '0;
         wp_q    <= '0;
         rp_q    <= '0;
         fill_q  <= '0;
      end else begin
         col_q   <= col_d;
         row_q   <= row_d;
         mode_q  <= mode_d;
         rdy_q   <= rdy_d;
         fd_q    <= fd_d;
         v1_q    <= v1_d;
         v2_q    <= v2_d;
         v3_q    <= v3_d;
         p1_q    <= p1_d;
         p2_q    <= p2_d;
         out3_q  <= out3_d;
         r1_q    <= r1_d;
         g1_q    <= g1_d;
         b1_q    <= b1_d;
         m1_q    <= m1_d;
         m2_q    <= m2_d;
         t1_q    <= t1_d;
         t2_q    <= t2_d;
         gray2_q <= gray2_d;
         tag1_q  <= tag1_d;
         tag2_q  <= tag2_d;
         tag3_q  <= tag3_d;
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         fill_q  <= fill_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (push) mem_q[wp_q] <= {tag3_q, out3_q};
   end

   // head is gated so stale storage never shows while the FIFO is empty
   always_comb begin
      head         = mem_q[rp_q];
      o_data_valid = fill_q != '0;
      o_data       = o_data_valid ? head[DW-1:0] : '0;
      o_sof        = o_data_valid && head[FW-1];
      o_eol        = o_data_valid && head[DW];
      o_data_ready = rdy_q;
      o_fill       = fill_q;
      o_frame_done = fd_q;
   end
endmodule

// File: tb/tb_vp_stream_core.sv
// tb_vp_stream_core: directed self-checking bench for vp_stream_core (RL=4, NROWS=2, 16-deep FIFO)
module tb_vp_stream_core;
   logic        i_clk = 1'b0;
   logic        i_rstn = 1'b0;
   logic [1:0]  i_mode = '0;
   logic [3:0]  i_thresh = '0;
   logic        i_data_valid = 1'b0;
   logic        o_data_ready;
   logic [11:0] i_data = '0;
   logic        i_data_ready = 1'b0;
   logic        o_data_valid;
   logic [11:0] o_data;
   logic        o_sof, o_eol;
   logic [4:0]  o_fill;
   logic        o_frame_done;

   int n_chk = 0, n_pass = 0, n_fail = 0, n_fd = 0;
   logic [13:0] popq [$];

   always #5 i_clk = ~i_clk;

   vp_stream_core #(.DW(12), .RL(4), .NROWS(2), .FIFO_AW(4)) dut (
      .i_clk(i_clk), .i_rstn(i_rstn), .i_mode(i_mode), .i_thresh(i_thresh),
      .i_data_valid(i_data_valid), .o_data_ready(o_data_ready), .i_data(i_data),
      .i_data_ready(i_data_ready), .o_data_valid(o_data_valid), .o_data(o_data),
      .o_sof(o_sof), .o_eol(o_eol), .o_fill(o_fill), .o_frame_done(o_frame_done)
   );

   // records every pixel that will be popped at the coming edge
   always @(negedge i_clk) begin
      if (i_rstn && o_data_valid && i_data_ready) popq.push_back({o_sof, o_eol, o_data});
      if (o_frame_done) n_fd++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic do_reset(input string tag);
      i_rstn = 1'b0;
      i_data_valid = 1'b0;
      tick();
      check({tag, "_rst_valid"}, 32'(o_data_valid), 0);
      check({tag, "_rst_fill"}, 32'(o_fill), 0);
      check({tag, "_rst_ready"}, 32'(o_data_ready), 0);
      check({tag, "_rst_data"}, 32'(o_data), 0);
      check({tag, "_rst_fd"}, 32'(o_frame_done), 0);
      popq.delete();
      n_fd = 0;
      i_rstn = 1'b1;
      tick();
      check({tag, "_ready_after_rst"}, 32'(o_data_ready), 1);
   endtask

   task automatic send(input logic [11:0] d);
      int w = 0;
      i_data = d;
      i_data_valid = 1'b1;
      while (!o_data_ready && w < 100) begin
         tick();
         w++;
      end
      if (w >= 100) check("send_timeout", 32'(o_data_ready), 1);
      tick();
      i_data_valid = 1'b0;
   endtask

   task automatic wait_pops(input int n, input string tag);
      int w = 0;
      while (popq.size() < n && w < 200) begin
         tick();
         w++;
      end
      check({tag, "_popcnt"}, 32'(popq.size()), 32'(n));
   endtask

   function automatic logic [13:0] tagd(input int i, input logic [11:0] d);
      return {i % 8 == 0, i % 4 == 3, d};
   endfunction

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      int n_acc;
      logic acc;
      do_reset("init");

      i_mode = 2'd0;
      i_data_ready = 1'b1;
      send(12'hA5C);
      tick();
      tick();
      check("m0_valid_early", 32'(o_data_valid), 0);
      tick();
      check("m0_valid", 32'(o_data_valid), 1);
      check("m0_data", 32'(o_data), 'hA5C);
      check("m0_fill1", 32'(o_fill), 1);
      check("m0_sof", 32'(o_sof), 1);
      check("m0_eol", 32'(o_eol), 0);
      tick();
      check("m0_fill0", 32'(o_fill), 0);
      check("m0_valid_off", 32'(o_data_valid), 0);

      do_reset("m1");
      i_mode = 2'd1;
      send(12'hF00);
      send(12'h0F0);
      send(12'hFFF);
      wait_pops(3, "m1");
      check("m1_px0", 32'(popq[0]), 'h2444);
      check("m1_px1", 32'(popq[1]), 'h0888);
      check("m1_px2", 32'(popq[2]), 'h0FFF);

      do_reset("m3");
      i_mode = 2'd3;
      i_thresh = 4'd8;
      send(12'h0F0);
      send(12'h00F);
      wait_pops(2, "m3");
      check("m3_px0", 32'(popq[0]), 'h2FFF);
      check("m3_px1", 32'(popq[1]), 'h0000);

      do_reset("m2");
      i_mode = 2'd2;
      send(12'hF00);
      wait_pops(1, "m2");
      check("m2_px0", 32'(popq[0]), 'h2BBB);

      do_reset("bp");
      i_mode = 2'd0;
      i_data_ready = 1'b0;
      n_acc = 0;
      for (int k = 0; k < 40; k++) begin
         i_data = 12'h100 + 12'(n_acc);
         i_data_valid = 1'b1;
         acc = o_data_ready;
         tick();
         if (acc) n_acc++;
      end
      i_data_valid = 1'b0;
      check("bp_accepts", 32'(n_acc), 16);
      check("bp_ready", 32'(o_data_ready), 0);
      check("bp_fill", 32'(o_fill), 16);
      i_data_ready = 1'b1;
      wait_pops(16, "bp");
      repeat (5) tick();
      check("bp_nodup", 32'(popq.size()), 16);
      check("bp_fill_end", 32'(o_fill), 0);
      for (int i = 0; i < 16; i++) check($sformatf("bp_px%0d", i), 32'(popq[i]), 32'(tagd(i, 12'h100 + 12'(i))));

      do_reset("fr");
      i_mode = 2'd1;
      for (int i = 0; i < 9; i++) begin
         if (i == 2) i_mode = 2'd0;
         send(12'hF00);
         if (i == 7) check("fr_done_pulse", 32'(o_frame_done), 1);
      end
      wait_pops(9, "fr");
      repeat (3) tick();
      check("fr_done_count", 32'(n_fd), 1);
      for (int i = 0; i < 9; i++) check($sformatf("fr_px%0d", i), 32'(popq[i]), 32'(tagd(i, i < 8 ? 12'h444 : 12'hF00)));

      do_reset("mid");
      i_mode = 2'd0;
      i_data_ready = 1'b0;
      for (int i = 0; i < 13; i++) send(12'h200 + 12'(i));
      check("mid_fill10", 32'(o_fill), 10);
      do_reset("mid");
      repeat (4) tick();
      check("mid_fill_stays0", 32'(o_fill), 0);
      i_data_ready = 1'b1;
      send(12'h123);
      wait_pops(1, "mid");
      repeat (5) tick();
      check("mid_single", 32'(popq.size()), 1);
      check("mid_px0", 32'(popq[0]), 'h2123);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
